issue_select: RTL

ISSUE_SELECT -- requirements
Module: issue_select

---
 rtl/issue_select_pkg.sv | 20 ++
 rtl/issue_select_rr_arbiter.sv | 29 ++
 rtl/issue_select.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/issue_select_pkg.sv
// Shared defaults, field widths and the clear-line bit-index helper for the
// issue select block.
package issue_select_pkg;

    localparam int NUM_ROWS_DEF = 8;
    localparam int NUM_COLS_DEF = 8;
    localparam int NUM_FUS_DEF  = 4;
    localparam int MAX_LAT_DEF  = 4;

    localparam int ROW_W_DEF = $clog2(NUM_ROWS_DEF);
    localparam int FU_W_DEF  = $clog2(NUM_FUS_DEF);
    localparam int COL_W_DEF = $clog2(NUM_COLS_DEF);
    localparam int LAT_W_DEF = $clog2(MAX_LAT_DEF + 1);

    // Position of the (fu, col) wakeup bit inside a clear_lines mask.
    function automatic int clr_bit_idx(input int fu, input int col, input int num_cols);
        return fu * num_cols + col;
    endfunction

endpackage

// File: rtl/issue_select_rr_arbiter.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter
    import issue_select_pkg::*;
#(
    parameter int N    = NUM_ROWS_DEF,
    parameter int PW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  request_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          valid_o
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!valid_o && request_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// Issue select: round-robin pick of one ready row per cycle, registered issue
// port, and a per-latency wakeup delay line producing dependency-clear pulses.
module issue_select
    import issue_select_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int NUM_COLS = NUM_COLS_DEF,
    parameter int NUM_FUS  = NUM_FUS_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    parameter int FUW  = (NUM_FUS  > 1) ? $clog2(NUM_FUS)  : 1,
    parameter int CW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    parameter int LATW = $clog2(MAX_LAT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ROWS-1:0]          request_vector,
    input  logic [NUM_ROWS*FUW-1:0]      row_fu,
    input  logic [NUM_ROWS*CW-1:0]       row_col,
    input  logic [NUM_ROWS*LATW-1:0]     row_lat,
    input  logic [NUM_FUS-1:0]           fu_ready,
    input  logic                         flush,
    output logic                         issue_valid,
    output logic [RW-1:0]                issue_row,
    output logic [FUW-1:0]               issue_fu,
    output logic                         free_en,
    output logic [RW-1:0]                free_row_index,
    output logic                         clear_en,
    output logic [NUM_COLS*NUM_FUS-1:0]  clear_lines
);

    localparam int LIW   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int MASKW = NUM_COLS * NUM_FUS;
    localparam int CLW   = (MASKW > 1) ? $clog2(MASKW) : 1;

    logic                              issue_valid_q, issue_valid_d;
    logic [RW-1:0]                     issue_row_q, issue_row_d;
    logic [FUW-1:0]                    issue_fu_q, issue_fu_d;
    logic [CW-1:0]                     issue_col_q, issue_col_d;
    logic [LIW-1:0]                    issue_lidx_q, issue_lidx_d;
    logic [RW-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [MAX_LAT-1:0][MASKW-1:0]     stage_q, stage_d;

    logic [NUM_ROWS-1:0] elig;
    logic [NUM_ROWS-1:0] gnt;
    logic                gnt_valid;
    logic [RW-1:0]       sel_row;
    logic [FUW-1:0]      sel_fu;
    logic [CW-1:0]       sel_col;
    logic [LIW-1:0]      sel_lidx;
    logic [CLW-1:0]      wake_bit;

    // A row is eligible when it requests, its FU is ready, and it is not the
    // row already sitting in the issue register.
    always_comb begin
        logic [FUW-1:0] fu;
        fu   = '0;
        elig = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            fu      = row_fu[i*FUW +: FUW];
            elig[i] = request_vector[i] & fu_ready[fu]
                      & ~(issue_valid_q && (issue_row_q == RW'(i)));
        end
    end

    rr_arbiter #(.N(NUM_ROWS), .PW(RW)) u_rr_arbiter (
        .request_i (elig),
        .ptr_i     (rr_ptr_q),
        .grant_o   (gnt),
        .valid_o   (gnt_valid)
    );

    // Decode the grant and fetch the winner's FU, column and saturated latency.
    always_comb begin
        int lat;
        sel_row = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (gnt[i]) sel_row = sel_row | RW'(i);
        end
        sel_fu  = row_fu[int'(sel_row)*FUW +: FUW];
        sel_col = row_col[int'(sel_row)*CW +: CW];
        lat     = int'(row_lat[int'(sel_row)*LATW +: LATW]);
        if (lat == 0)      lat = 1;
        if (lat > MAX_LAT) lat = MAX_LAT;
        sel_lidx = LIW'(lat - 1);
    end

    // Next state: wakeups are loaded from the issue register, so stage L-1 is
    // filled the cycle issue_valid is high and reaches stage 0 L cycles later.
    always_comb begin
        issue_valid_d = gnt_valid;
        issue_row_d   = issue_row_q;
        issue_fu_d    = issue_fu_q;
        issue_col_d   = issue_col_q;
        issue_lidx_d  = issue_lidx_q;
        rr_ptr_d      = rr_ptr_q;
        wake_bit      = CLW'(clr_bit_idx(int'(issue_fu_q), int'(issue_col_q), NUM_COLS));

        stage_d = '0;
        for (int s = 0; s < MAX_LAT - 1; s++) begin
            stage_d[s] = stage_q[s+1];
        end
        if (issue_valid_q) begin
            stage_d[issue_lidx_q][wake_bit] = 1'b1;
        end

        if (gnt_valid) begin
            issue_row_d  = sel_row;
            issue_fu_d   = sel_fu;
            issue_col_d  = sel_col;
            issue_lidx_d = sel_lidx;
            rr_ptr_d     = (sel_row == RW'(NUM_ROWS - 1)) ? '0 : sel_row + 1'b1;
        end

        if (flush) begin
            issue_valid_d = 1'b0;
            issue_row_d   = '0;
            issue_fu_d    = '0;
            issue_col_d   = '0;
            issue_lidx_d  = '0;
            rr_ptr_d      = rr_ptr_q;
            stage_d       = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_valid_q <= 1'b0;
            issue_row_q   <= '0;
            issue_fu_q    <= '0;
            issue_col_q   <= '0;
            issue_lidx_q  <= '0;
            rr_ptr_q      <= '0;
            stage_q       <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_row_q   <= issue_row_d;
            issue_fu_q    <= issue_fu_d;
            issue_col_q   <= issue_col_d;
            issue_lidx_q  <= issue_lidx_d;
            rr_ptr_q      <= rr_ptr_d;
            stage_q       <= stage_d;
        end
    end

    assign issue_valid    = issue_valid_q;
    assign issue_row      = issue_row_q;
    assign issue_fu       = issue_fu_q;
    assign free_en        = issue_valid_q;
    assign free_row_index = issue_row_q;
    assign clear_lines    = stage_q[0];
    assign clear_en       = |stage_q[0];

endmodule
